fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined core. Generates sequential fetch PCs and issues them to instruction memory over a valid/ready request channel, with up to DEPTH requests in flight. In-order responses are buffered, each paired with its PC, in a DEPTH-entry queue feeding decode over a valid/ready handshake. A redirect from execute flushes the queue, restarts fetch at the new PC and discards every stale in-flight response.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_queue_unit.sv | 115 +++++++++++
 tb/tb_fetch_queue_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch front-end definitions: default widths, reset PC, queue entry layout.
package fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ILEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  // addi x0,x0,0: the bubble decode inserts when no instruction is available
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from the entry registers.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited requests,
// in-order response queue to decode, and redirect flush with stale-response dropping.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_rsp_valid_i,
  input  logic [ILEN-1:0] imem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic            fifo_empty, fifo_full;
  entry_t          push_entry, head;
  logic            credit_ok, req_fire, rsp_ok, push, pop;

  // Queued plus in-flight entries never exceed DEPTH, so a push always has room.
  assign credit_ok        = ({1'b0, count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid_o = run_q & ~redirect_i & credit_ok;
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  assign rsp_ok = imem_rsp_valid_i & (outstanding_q != '0);
  assign push   = rsp_ok & (drop_q == '0) & ~redirect_i;

  assign inst_valid_o = ~fifo_empty & ~redirect_i;
  assign pop          = inst_valid_o & inst_ready_i;
  assign inst_o       = head.inst;
  assign inst_pc_o    = head.pc;
  assign push_entry   = '{pc: rsp_pc_q, inst: imem_rsp_data_i};

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .head_o  (head),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect_i) begin
      // Every request still in flight becomes stale; one arriving now is discarded here.
      fetch_pc_d    = redirect_pc_i;
      rsp_pc_d      = redirect_pc_i;
      outstanding_d = outstanding_q - CW'(rsp_ok);
      drop_d        = outstanding_q - CW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(4);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_ok && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      run_q         <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  rsp_has_credit_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> (outstanding_q != '0));

  no_push_when_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit with an in-order random-latency memory model.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, rst_ni;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  fetch_queue_unit #(
    .XLEN     (32),
    .ILEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_addr_o  (imem_req_addr),
    .imem_req_ready_i (imem_req_ready),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .inst_valid_o     (inst_valid),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .inst_ready_i     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_pc;
    int unsigned epoch;
    int          due;
  } pend_t;

  pend_t        pend[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  addr_q[$];

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned epoch = 0, fires = 0, rel_cycles = 0;
  int          cyc = 0, last_due = 0;
  logic [31:0] req_pc_m = RESET_PC;
  int unsigned pushed_now = 0, stale_now = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    pend.delete(); exp_q.delete(); addr_q.delete();
    epoch++; req_pc_m = RESET_PC; last_due = cyc; pushed_now = 0; stale_now = 0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check("first_cycle_no_req", 32'(imem_req_valid), 32'd0);
    rel_cycles = 1;
  endtask

  // One cycle of stimulus plus the memory model; expected entries only for current-epoch responses.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit mem_rdy,
                      input bit dec_rdy, input int lat);
    pend_t p;
    bit    exp_rv;
    int    due;
    @(negedge clk);
    cyc++;
    pushed_now = 0; stale_now = 0;
    redirect = redir; redirect_pc = rpc; imem_req_ready = mem_rdy; inst_ready = dec_rdy;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if (redir) begin
      epoch++; exp_q.delete(); req_pc_m = rpc;
    end
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(p.addr);
      if (p.epoch == epoch) begin
        exp_q.push_back('{pc: p.exp_pc, inst: mem_word(p.exp_pc)});
        pushed_now = 1;
      end else stale_now = 1;
    end
    #1;
    exp_rv = (rel_cycles != 0) && !redir && (pend.size() + exp_q.size() + stale_now < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (imem_req_valid && mem_rdy) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: imem_req_addr, exp_pc: req_pc_m, epoch: epoch, due: due});
      addr_q.push_back(req_pc_m);
      req_pc_m += 32'd4;
      fires++;
    end
  endtask

  // Monitor: compares request addresses and every instruction handed to decode.
  always @(negedge clk) begin
    fetch_entry_t e;
    logic [31:0]  a;
    #2;
    if (rst_ni) begin
      if (imem_req_valid && imem_req_ready) begin
        if (addr_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
        else begin
          a = addr_q.pop_front();
          check("req_addr", imem_req_addr, a);
        end
      end
      check("inst_valid", 32'(inst_valid), 32'(!redirect && exp_q.size() > pushed_now));
      if (inst_valid && inst_ready) begin
        if (exp_q.size() <= pushed_now) check("pop_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst", inst, e.inst);
        end
      end
    end
  end

  initial begin
    int unsigned f0;
    rst_ni = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    do_reset();

    // Streaming from reset, L=1
    repeat (20) step(0, '0, 1, 1, 1);

    // Decode stalled: credit limit, then one pop frees exactly one slot
    step(1, 32'h200, 1, 0, 1);
    f0 = fires;
    repeat (10) step(0, '0, 1, 0, 1);
    check("stall_fires", fires - f0, DEPTH);
    f0 = fires;
    step(0, '0, 1, 1, 1);
    repeat (6) step(0, '0, 1, 0, 1);
    check("one_pop_one_fire", fires - f0, 32'd1);
    repeat (8) step(0, '0, 1, 1, 1);

    // Three requests in flight, then redirect to 0x100
    step(1, 32'h40, 1, 1, 6);
    f0 = fires;
    repeat (3) step(0, '0, 1, 1, 6);
    check("three_in_flight", fires - f0, 32'd3);
    step(1, 32'h100, 0, 1, 1);
    repeat (15) step(0, '0, 1, 1, 1);

    // Redirect coinciding with a response and a pop
    repeat (6) step(0, '0, 1, 1, 1);
    step(1, 32'h300, 1, 1, 1);
    repeat (8) step(0, '0, 1, 1, 1);

    // Address wrap past 0xFFFF_FFFC
    step(1, 32'hFFFF_FFF8, 1, 1, 1);
    repeat (10) step(0, '0, 1, 1, 2);

    // Reset mid-operation with entries queued and requests outstanding
    repeat (4) step(0, '0, 1, 0, 3);
    do_reset();
    repeat (12) step(0, '0, 1, 1, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      logic [31:0] pc;
      r  = ($urandom_range(0, 99) < 4);
      pc = $urandom();
      if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
      step(r, pc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           int'($urandom_range(1, 4)));
    end
    repeat (12) step(0, '0, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
